// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC register, single-outstanding imem read handshake,
// registered IF/ID slot with a one-entry skid buffer and redirect flush.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SKID = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_drop;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;

    logic        w_consume;
    logic        w_slot_free;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redirect_pc;

    assign w_consume     = r_if_valid & ~stall;
    assign w_slot_free   = ~r_if_valid | ~stall;
    assign w_pc_inc      = r_pc + 32'd4;
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    // Fetch FSM, PC, drop flag, skid buffer and IF/ID slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc    <= 32'h0000_0000;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'h0000_0000;
            r_if_instr   <= NOP_INSTR;
        end else if (redirect_valid) begin
            // Redirect wins over stall; an in-flight read must still be drained.
            r_pc       <= w_redirect_pc;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            case (r_state)
                ST_REQ: begin
                    if (imem_ready) begin
                        r_state <= ST_WAIT;
                        r_drop  <= 1'b1;
                    end else begin
                        r_state <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= ST_REQ;
                        r_drop  <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                        r_drop  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end else begin
            if (w_consume) begin
                r_if_valid <= 1'b0;
                r_if_instr <= NOP_INSTR;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= ST_REQ;
                        end else if (w_slot_free) begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_instr <= imem_rdata;
                            r_pc       <= w_pc_inc;
                            r_state    <= ST_REQ;
                        end else begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc    <= r_pc;
                            r_pc         <= w_pc_inc;
                            r_state      <= ST_SKID;
                        end
                    end
                end
                ST_SKID: begin
                    if (w_consume) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_skid_pc;
                        r_if_instr <= r_skid_instr;
                        r_state    <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req       = (r_state == ST_REQ);
    assign imem_addr      = r_pc;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instruction = r_if_instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: two instances (RESET_PC 0 and
// 0xFFFF_FFFC) share stimulus; memory responses are driven step by step.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;

    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        vld0, vld1;
    logic [31:0] pc0, pc1;
    logic [31:0] ins0, ins1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .imem_req(req0), .imem_addr(addr0), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(vld0), .if_pc(pc0), .if_instruction(ins0)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .imem_req(req1), .imem_addr(addr1), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_valid(vld1), .if_pc(pc1), .if_instruction(ins1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0000_0000;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        stall          = 1'b0;
        reset_n        = 1'b0;
        tick();
        tick();
    endtask

    // Reset, fetch pc=0, stall, and let the pc=4 response land in the skid.
    task automatic reach_skid(input string tag);
        do_reset();
        reset_n = 1'b1;
        tick();
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        stall = 1'b1;
        tick();
        chk({tag, "_hold_valid"}, {31'd0, vld0}, 32'd1);
        chk({tag, "_hold_pc"}, pc0, 32'h0000_0000);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0017;
        tick();
        imem_rvalid = 1'b0;
        chk({tag, "_skid_noreq"}, {31'd0, req0}, 32'd0);
        chk({tag, "_skid_pc"}, pc0, 32'h0000_0000);
        chk({tag, "_skid_ins"}, ins0, 32'h0000_0013);
    endtask

    initial begin
        // Test 1: reset state and three sequential fetches.
        do_reset();
        chk("rst_req", {31'd0, req0}, 32'd0);
        chk("rst_addr", addr0, 32'h0000_0000);
        chk("rst_valid", {31'd0, vld0}, 32'd0);
        chk("rst_pc", pc0, 32'h0000_0000);
        chk("rst_ins", ins0, 32'h0000_0013);
        chk("rst_addr1", addr1, 32'hFFFF_FFFC);
        reset_n = 1'b1;
        tick();
        chk("t1_req0", {31'd0, req0}, 32'd1);
        chk("t1_addr0", addr0, 32'h0000_0000);
        tick();
        chk("t1_wait_noreq", {31'd0, req0}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 1'b0;
        chk("t1_v0", {31'd0, vld0}, 32'd1);
        chk("t1_pc0", pc0, 32'h0000_0000);
        chk("t1_ins0", ins0, 32'h0000_0013);
        chk("t1_addr4", addr0, 32'h0000_0004);
        chk("t1_req4", {31'd0, req0}, 32'd1);
        tick();
        chk("t1_consumed", {31'd0, vld0}, 32'd0);
        chk("t1_pc_hold", pc0, 32'h0000_0000);
        chk("t1_nop", ins0, 32'h0000_0013);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0017;
        tick();
        imem_rvalid = 1'b0;
        chk("t1_pc4", pc0, 32'h0000_0004);
        chk("t1_ins4", ins0, 32'h0000_0017);
        chk("t1_addr8", addr0, 32'h0000_0008);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_001B;
        tick();
        imem_rvalid = 1'b0;
        chk("t1_v8", {31'd0, vld0}, 32'd1);
        chk("t1_pc8", pc0, 32'h0000_0008);
        chk("t1_ins8", ins0, 32'h0000_001B);

        // Test 2: stall with skid, then release.
        reach_skid("t2");
        tick();
        chk("t2_still_noreq", {31'd0, req0}, 32'd0);
        chk("t2_still_pc", pc0, 32'h0000_0000);
        stall = 1'b0;
        tick();
        chk("t2_rel_pc", pc0, 32'h0000_0004);
        chk("t2_rel_ins", ins0, 32'h0000_0017);
        chk("t2_rel_valid", {31'd0, vld0}, 32'd1);
        chk("t2_rel_req", {31'd0, req0}, 32'd1);
        chk("t2_rel_addr", addr0, 32'h0000_0008);

        // Test 3: redirect to 0x103 while request for 0x8 is accepted.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", {31'd0, vld0}, 32'd0);
        chk("t3_flush_ins", ins0, 32'h0000_0013);
        chk("t3_noreq", {31'd0, req0}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_001B;
        tick();
        imem_rvalid = 1'b0;
        chk("t3_drop_valid", {31'd0, vld0}, 32'd0);
        chk("t3_new_req", {31'd0, req0}, 32'd1);
        chk("t3_new_addr", addr0, 32'h0000_0100);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0113;
        tick();
        imem_rvalid = 1'b0;
        chk("t3_pc100", pc0, 32'h0000_0100);
        chk("t3_ins100", ins0, 32'h0000_0113);
        chk("t3_v100", {31'd0, vld0}, 32'd1);
        imem_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0302;
        tick();
        redirect_valid = 1'b0;
        chk("t3_req_stay", {31'd0, req0}, 32'd1);
        chk("t3_req_addr", addr0, 32'h0000_0300);
        imem_ready = 1'b1;

        // Test 4: redirect while skid is full and decode stalled.
        reach_skid("t4");
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("t4_valid", {31'd0, vld0}, 32'd0);
        chk("t4_ins", ins0, 32'h0000_0013);
        chk("t4_req", {31'd0, req0}, 32'd1);
        chk("t4_addr", addr0, 32'h0000_0200);
        stall = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0213;
        tick();
        imem_rvalid = 1'b0;
        chk("t4_pc200", pc0, 32'h0000_0200);
        chk("t4_ins200", ins0, 32'h0000_0213);

        // Test 5: PC wrap from 0xFFFF_FFFC.
        do_reset();
        reset_n = 1'b1;
        tick();
        chk("t5_req", {31'd0, req1}, 32'd1);
        chk("t5_addr", addr1, 32'hFFFF_FFFC);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_rvalid = 1'b0;
        chk("t5_pc", pc1, 32'hFFFF_FFFC);
        chk("t5_ins", ins1, 32'hFFFF_FFFF);
        chk("t5_wrap_addr", addr1, 32'h0000_0000);

        // Test 6: reset in WAIT, stray rvalid before the first new request.
        tick();
        reset_n = 1'b0;
        tick();
        chk("t6_rst_pc", pc1, 32'h0000_0000);
        chk("t6_rst_valid", {31'd0, vld1}, 32'd0);
        chk("t6_rst_ins", ins1, 32'h0000_0013);
        chk("t6_rst_req", {31'd0, req1}, 32'd0);
        chk("t6_rst_addr", addr1, 32'hFFFF_FFFC);
        reset_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("t6_stray_valid", {31'd0, vld1}, 32'd0);
        chk("t6_first_req", {31'd0, req1}, 32'd1);
        chk("t6_first_addr", addr1, 32'hFFFF_FFFC);
        tick();
        chk("t6_after_valid", {31'd0, vld1}, 32'd0);
        chk("t6_after_ins", ins1, 32'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
